// File: rtl/serial_pattern_gen_pkg.sv
// -----------------------------------------------------------------------------
// serial_pattern_gen_pkg
// Definitions shared by the serial pattern generator and the sequence detector
// side of the datapath.
//   state_e          : frame FSM encoding (IDLE -> SEND -> DONE -> IDLE)
//   DEFAULT_RUN_LEN  : run length of equal bits that raises the detector flag
//   idx_width()      : width of a bit index that can address 'width' bits
// -----------------------------------------------------------------------------
package serial_pattern_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEFAULT_RUN_LEN = 4;

  // Never returns less than 1, so a 1-bit-wide index still gets a real vector.
  function automatic int idx_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_pattern_gen_run_len_tracker.sv
// -----------------------------------------------------------------------------
// run_len_tracker
// Golden model of the sequence detector flag: tracks how many consecutive
// equal bits have been seen (saturating at RUN_LEN) and raises run_hit while
// the run is at RUN_LEN. The first bit after a clear always starts a run of 1.
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   clear      : start a new stream (run count and run_hit go to 0)
//   bit_valid  : bit_in is a new stream bit this cycle
//   bit_in     : stream bit
//   run_hit    : registered, high while the last RUN_LEN bits are equal
// -----------------------------------------------------------------------------
module run_len_tracker
  import serial_pattern_gen_pkg::*;
#(
  parameter int RUN_LEN = DEFAULT_RUN_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic bit_valid,
  input  logic bit_in,
  output logic run_hit
);

  localparam int               CNT_W   = $clog2(RUN_LEN + 1);
  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] RUN_ONE = CNT_W'(1);

  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] run_nxt;
  logic             prev_bit;

  // A zero count means "no bit yet in this stream", so the next bit is a
  // fresh run regardless of prev_bit.
  always_comb begin
    // NOTE: default first so every path assigns run_nxt; otherwise a latch is inferred.
    run_nxt = RUN_ONE;
    if (run_cnt != '0 && bit_in == prev_bit) begin
      run_nxt = (run_cnt == RUN_MAX) ? RUN_MAX : run_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cnt  <= '0;
      prev_bit <= 1'b0;
      run_hit  <= 1'b0;
    end else if (clear) begin
      run_cnt <= '0;
      run_hit <= 1'b0;
    end else if (bit_valid) begin
      run_cnt  <= run_nxt;
      prev_bit <= bit_in;
      run_hit  <= (run_nxt == RUN_MAX);
    end
  end

endmodule

// File: rtl/serial_pattern_gen.sv
// -----------------------------------------------------------------------------
// serial_pattern_gen
// Transmit end of the single-bit 'w' stream consumed by the sequence detector.
// Captures a PAT_W-bit pattern and a repeat count on an accepted start, then
// emits the pattern MSB-first, one bit per tick, 'reps' times back-to-back.
// expect_z is a registered reference of the detector flag for the same stream.
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   start     : begin a frame (accepted only while ready)
//   pattern   : bits to emit, captured on accepted start
//   reps      : number of repetitions, captured on accepted start (0 = none)
//   tick      : bit-rate enable, one bit per tick while sending
//   ready     : high in IDLE only
//   w         : serial data bit, held between ticks
//   w_valid   : one-cycle pulse when a new w is presented
//   expect_z  : high when the last RUN_LEN emitted bits of the frame are equal
//   done      : one-cycle pulse when the frame completes
// -----------------------------------------------------------------------------
module serial_pattern_gen
  import serial_pattern_gen_pkg::*;
#(
  parameter int PAT_W   = 8,
  parameter int REP_W   = 4,
  parameter int RUN_LEN = DEFAULT_RUN_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [REP_W-1:0] reps,
  input  logic             tick,
  output logic             ready,
  output logic             w,
  output logic             w_valid,
  output logic             expect_z,
  output logic             done
);

  localparam int               IDX_W    = idx_width(PAT_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);
  localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

  state_e           state;
  logic [PAT_W-1:0] shift_reg;
  logic [IDX_W-1:0] bit_idx;
  logic [REP_W-1:0] rep_cnt;

  logic accept;
  logic emit;
  logic next_bit;

  assign ready    = (state == ST_IDLE);
  assign accept   = ready && start;
  assign emit     = (state == ST_SEND) && tick;
  assign next_bit = shift_reg[bit_idx];

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the pattern register is reset along with the control state; it is a
    // single word, and a defined value keeps next_bit clean out of reset.
    if (!rst) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      bit_idx   <= '0;
      rep_cnt   <= '0;
      w         <= 1'b0;
      w_valid   <= 1'b0;
      done      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // the pre-edge values regardless of statement order.
      w_valid <= 1'b0;
      done    <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          // tick is deliberately ignored here, even alongside start.
          if (start) begin
            shift_reg <= pattern;
            bit_idx   <= IDX_LAST;
            rep_cnt   <= reps;
            state     <= (reps == '0) ? ST_DONE : ST_SEND;
          end
        end
        ST_SEND: begin
          if (tick) begin
            w       <= next_bit;
            w_valid <= 1'b1;
            if (bit_idx == '0) begin
              bit_idx <= IDX_LAST;
              rep_cnt <= rep_cnt - 1'b1;
              if (rep_cnt == REP_ONE) begin
                state <= ST_DONE;
              end
            end else begin
              bit_idx <= bit_idx - 1'b1;
            end
          end
        end
        ST_DONE: begin
          // done appears the cycle after the final bit was registered.
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Runs carry across repetitions because the tracker only clears on start.
  run_len_tracker #(
    .RUN_LEN (RUN_LEN)
  ) u_run_len_tracker (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept),
    .bit_valid (emit),
    .bit_in    (next_bit),
    .run_hit   (expect_z)
  );

endmodule
